// File: rtl/pwm_code_rx.sv
// Pulse-width-coded frame receiver: sync pair, MSB-first data bits, end low, idle high.
// Define PWM_CODE_RX_PARITY_EN to append and check an even-parity bit after the payload.
`timescale 1ns/1ps
module pwm_code_rx #(
    parameter int CODE_WIDTH  = 26,
    parameter int DATA_PERIOD = 20,
    parameter int MARGIN      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  data_in,
    output logic [2:0]            state_out,
    output logic [CODE_WIDTH-1:0] code_out,
    output logic                  new_code_out,
    output logic                  err_out,
    output logic [2:0]            err_code_out
);

    localparam int H = DATA_PERIOD / 2;
    localparam int Q = DATA_PERIOD / 4;
    localparam int T = 3 * DATA_PERIOD / 4;
`ifdef PWM_CODE_RX_PARITY_EN
    localparam int FRAME_LEN = CODE_WIDTH + 1;
`else
    localparam int FRAME_LEN = CODE_WIDTH;
`endif
    localparam int CNT_W  = $clog2(DATA_PERIOD + MARGIN + 2);
    localparam int BCNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0, SL = 3'd1, SH = 3'd2, DL = 3'd3,
        DH0  = 3'd4, DH1 = 3'd5, DONE = 3'd6
    } state_t;

    function automatic logic in_win(input int c, input int x);
        return (c >= x - MARGIN) && (c <= x + MARGIN);
    endfunction

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sp_reg;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       counter_reg, counter_next;
    logic [BCNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [FRAME_LEN-1:0]   buf_reg, buf_next;
    logic [CODE_WIDTH-1:0]  code_reg, code_next;
    logic                   new_code_reg, new_code_next;
    logic                   err_reg, err_next;
    logic [2:0]             err_code_reg, err_code_next;

    logic s, edge_det, abort, shift_en, shift_bit;
    logic [2:0] abort_code;
    int cnt;

    assign s         = sync_reg[SYNC_STAGES-1];
    assign edge_det  = s ^ sp_reg;
    assign cnt       = int'(counter_reg);
    assign state_out    = state_reg;
    assign code_out     = code_reg;
    assign new_code_out = new_code_reg;
    assign err_out      = err_reg;
    assign err_code_out = err_code_reg;

    // Synchroniser and previous-sample flop reset to the idle-high level.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_reg <= '1;
            sp_reg   <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], data_in};
            sp_reg   <= s;
        end
    end

    always_comb begin
        state_next    = state_reg;
        counter_next  = edge_det ? CNT_W'(1) :
                        (counter_reg == CNT_MAX ? counter_reg : counter_reg + 1'b1);
        bit_cnt_next  = bit_cnt_reg;
        buf_next      = buf_reg;
        code_next     = code_reg;
        new_code_next = 1'b0;
        err_next      = 1'b0;
        err_code_next = err_code_reg;
        abort         = 1'b0;
        abort_code    = 3'd0;
        shift_en      = 1'b0;
        shift_bit     = 1'b0;

        // The counter value on an edge is the length of the interval just ended.
        case (state_reg)
            IDLE: begin
                if (edge_det && !s) begin
                    state_next   = SL;
                    bit_cnt_next = '0;
                end
            end
            SL: begin
                if (edge_det) begin
                    if (in_win(cnt, H)) state_next = SH;
                    else begin abort = 1'b1; abort_code = 3'd1; end
                end else if (cnt > H + MARGIN) begin
                    abort = 1'b1; abort_code = 3'd1;
                end
            end
            SH: begin
                if (edge_det) begin
                    if (in_win(cnt, H)) state_next = DL;
                    else begin abort = 1'b1; abort_code = 3'd2; end
                end else if (cnt > H + MARGIN) begin
                    abort = 1'b1; abort_code = 3'd2;
                end
            end
            DL: begin
                if (edge_det) begin
                    if (in_win(cnt, Q))      state_next = DH0;
                    else if (in_win(cnt, T)) state_next = DH1;
                    else begin abort = 1'b1; abort_code = 3'd3; end
                end else if (cnt > T + MARGIN) begin
                    abort = 1'b1; abort_code = 3'd3;
                end
            end
            DH0: begin
                if (edge_det) begin
                    if (in_win(cnt, T)) shift_en = 1'b1;
                    else begin abort = 1'b1; abort_code = 3'd4; end
                end else if (cnt > T + MARGIN) begin
                    abort = 1'b1; abort_code = 3'd4;
                end
            end
            DH1: begin
                shift_bit = 1'b1;
                if (edge_det) begin
                    if (in_win(cnt, Q)) shift_en = 1'b1;
                    else begin abort = 1'b1; abort_code = 3'd4; end
                end else if (cnt > Q + MARGIN) begin
                    abort = 1'b1; abort_code = 3'd4;
                end
            end
            DONE: begin
                if (edge_det) begin
`ifdef PWM_CODE_RX_PARITY_EN
                    if (^buf_reg) begin
                        abort = 1'b1; abort_code = 3'd5;
                    end else
`endif
                    begin
                        code_next     = buf_reg[FRAME_LEN-1 -: CODE_WIDTH];
                        new_code_next = 1'b1;
                        state_next    = IDLE;
                    end
                end else if (cnt > DATA_PERIOD + MARGIN) begin
                    abort = 1'b1; abort_code = 3'd6;
                end
            end
            default: state_next = IDLE;
        endcase

        if (shift_en) begin
            buf_next     = (buf_reg << 1) | FRAME_LEN'(shift_bit);
            bit_cnt_next = bit_cnt_reg + 1'b1;
            state_next   = (int'(bit_cnt_reg) + 1 == FRAME_LEN) ? DONE : DL;
        end

        if (abort) begin
            state_next    = IDLE;
            err_next      = 1'b1;
            err_code_next = abort_code;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            bit_cnt_reg  <= '0;
            buf_reg      <= '0;
            code_reg     <= '0;
            new_code_reg <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            bit_cnt_reg  <= bit_cnt_next;
            buf_reg      <= buf_next;
            code_reg     <= code_next;
            new_code_reg <= new_code_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

endmodule

// File: tb/tb_pwm_code_rx.sv
// Scoreboard bench for pwm_code_rx: directed frames push expected pulses, a monitor pops and checks them.
`timescale 1ns/1ps
module tb_pwm_code_rx;
    localparam int CW = 26;
    localparam int DP = 20;
    localparam int MG = 2;
    localparam int SS = 2;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic          data_in = 1'b1;
    logic [2:0]    state_out;
    logic [CW-1:0] code_out;
    logic          new_code_out;
    logic          err_out;
    logic [2:0]    err_code_out;

    pwm_code_rx #(.CODE_WIDTH(CW), .DATA_PERIOD(DP), .MARGIN(MG), .SYNC_STAGES(SS)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in),
        .state_out(state_out), .code_out(code_out), .new_code_out(new_code_out),
        .err_out(err_out), .err_code_out(err_code_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        logic [CW-1:0] code;
        logic [2:0]    errc;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int rise_cyc = 0;
    logic [CW-1:0] last_code = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_code(input logic [CW-1:0] c);
        exp_t e;
        e.is_err = 1'b0; e.code = c; e.errc = 3'd0;
        exp_q.push_back(e);
        last_code = c;
    endtask

    task automatic push_err(input logic [2:0] ec);
        exp_t e;
        e.is_err = 1'b1; e.code = last_code; e.errc = ec;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic lvl, input int n);
        data_in = lvl;
        repeat (n) @(negedge clk_in);
    endtask

    // d stretches every interval; bad_bit gets a malformed low then idles; stop_bit cuts the frame mid-bit.
    task automatic send_frame(input logic [CW-1:0] code, input int d, input bit flip_par,
                              input int bad_bit, input int bad_low, input int stop_bit, input int end_low);
        logic [CW:0] bits;
        int nb;
`ifdef PWM_CODE_RX_PARITY_EN
        bits = {code, (^code) ^ flip_par};
        nb = CW + 1;
`else
        bits = {flip_par, code};
        nb = CW;
`endif
        hold(1'b0, 10 + d);
        hold(1'b1, 10 + d);
        for (int i = 0; i < nb; i++) begin
            logic b;
            b = bits[nb-1-i];
            if (i == stop_bit) begin
                hold(1'b0, 3);
                return;
            end
            if (i == bad_bit) begin
                hold(1'b0, bad_low);
                hold(1'b1, 40);
                return;
            end
            if (b) begin hold(1'b0, 15 + d); hold(1'b1, 5 + d); end
            else   begin hold(1'b0, 5 + d);  hold(1'b1, 15 + d); end
        end
        hold(1'b0, end_low);
        rise_cyc = cyc;
        hold(1'b1, 30);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_state"}, 32'(state_out), 32'd0);
        check({tag, "_code"}, 32'(code_out), 32'd0);
        check({tag, "_new_code"}, 32'(new_code_out), 32'd0);
        check({tag, "_err"}, 32'(err_out), 32'd0);
        check({tag, "_err_code"}, 32'(err_code_out), 32'd0);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk_in) begin
        if (new_code_out && err_out)
            check("pulse_overlap", 32'd1, 32'd0);
        if (new_code_out || err_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, err_code_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", 32'(err_out), 32'(e.is_err));
                if (e.is_err == err_out) begin
                    if (e.is_err) begin
                        check("err_code", 32'(err_code_out), 32'(e.errc));
                        check("code_held", 32'(code_out), 32'(e.code));
                    end else begin
                        check("code", 32'(code_out), 32'(e.code));
                        check("latency", 32'(cyc - rise_cyc), 32'(SS + 1));
                    end
                end
            end
        end
    end

    initial begin
        #1 rst_n_in = 1'b0;
        data_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check_zero_outputs("reset");
        rst_n_in = 1'b1;
        hold(1'b1, 10);

        // Stuck-low line: one sync-low timeout, then no re-arm.
        push_err(3'd1);
        hold(1'b0, 200);
        check("stuck_low_idle", 32'(state_out), 32'd0);
        hold(1'b1, 20);

        push_code(26'h2A5F0C3);
        send_frame(26'h2A5F0C3, 0, 1'b0, -1, 0, -1, 10);
        push_code(26'h2A5F0C3);
        send_frame(26'h2A5F0C3, 2, 1'b0, -1, 0, -1, 12);
        push_code(26'h2A5F0C3);
        send_frame(26'h2A5F0C3, -2, 1'b0, -1, 0, -1, 8);

        push_err(3'd1);
        hold(1'b0, 13);
        hold(1'b1, 40);

        push_err(3'd3);
        send_frame(26'h2A5F0C3, 0, 1'b0, 7, 10, -1, 10);
        push_code(26'h0000001);
        send_frame(26'h0000001, 0, 1'b0, -1, 0, -1, 10);

        push_err(3'd6);
        send_frame(26'h2A5F0C3, 0, 1'b0, -1, 0, -1, 30);

        // Asynchronous reset mid-bit 12: partial frame dropped silently.
        send_frame(26'h1555555, 0, 1'b0, -1, 0, 12, 10);
        #2 rst_n_in = 1'b0;
        #1 check_zero_outputs("async_reset");
        last_code = '0;
        data_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        hold(1'b1, 10);

        push_code(26'h3FFFFFF);
        send_frame(26'h3FFFFFF, 0, 1'b0, -1, 0, -1, 10);

`ifdef PWM_CODE_RX_PARITY_EN
        push_code(26'h0000003);
        send_frame(26'h0000003, 0, 1'b0, -1, 0, -1, 10);
        push_err(3'd5);
        send_frame(26'h0000003, 0, 1'b1, -1, 0, -1, 10);
`endif

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk_in);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        hold(1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
